// File: rtl/nonce_sequencer_if.sv
// nonce_sequencer_if: job, hasher issue, hit and golden-ticket signals of the nonce sequencer.
// master is the sequencer side, slave the surrounding job/hasher/UART side.
interface nonce_sequencer_if;
   logic         new_work;
   logic [255:0] midstate;
   logic [95:0]  work_data;
   logic [31:0]  nonce_min;
   logic [31:0]  nonce_max;
   logic         hash_ready;
   logic         hash_valid;
   logic [255:0] hash_midstate;
   logic [95:0]  hash_data;
   logic [31:0]  hash_nonce;
   logic [1:0]   hash_job;
   logic         hit;
   logic [31:0]  hit_nonce;
   logic [1:0]   hit_job;
   logic [31:0]  golden_nonce;
   logic         new_golden_ticket;
   logic         busy;
   logic         overflow;
   modport master (
      input  new_work, midstate, work_data, nonce_min, nonce_max, hash_ready, hit, hit_nonce, hit_job,
      output hash_valid, hash_midstate, hash_data, hash_nonce, hash_job, golden_nonce, new_golden_ticket,
             busy, overflow
   );
   modport slave (
      output new_work, midstate, work_data, nonce_min, nonce_max, hash_ready, hit, hit_nonce, hit_job,
      input  hash_valid, hash_midstate, hash_data, hash_nonce, hash_job, golden_nonce, new_golden_ticket,
             busy, overflow
   );
endinterface

// File: rtl/nonce_sequencer.sv
// nonce_sequencer: sweeps a job's nonce range into the hasher and paces hasher hits back as golden tickets.
// Define NONCE_SEQ_STALE_FILTER_EN to drop hits whose job tag differs from the current job.
module nonce_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TICKET_GAP = 64
) (
   input logic hash_clk,
   input logic rst_n,
   nonce_sequencer_if.master bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = TICKET_GAP > 1 ? $clog2(TICKET_GAP) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_d;
   logic [31:0] nonce_d, nonce_max_q;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [GW-1:0] gap;
   logic xfer, last, accept, empty, full, pop, push, drop;
   assign bus.hash_valid = state == RUN;
   assign bus.busy = state == RUN;
   assign xfer = bus.hash_valid && bus.hash_ready;
   assign last = bus.hash_nonce == nonce_max_q;
`ifdef NONCE_SEQ_STALE_FILTER_EN
   assign accept = bus.hit && bus.hit_job == bus.hash_job;
`else
   logic unused_hit_job;
   assign unused_hit_job = ^bus.hit_job;
   assign accept = bus.hit;
`endif
   // pointers carry one extra wrap bit so full and empty are distinguishable
   assign empty = wr_ptr == rd_ptr;
   assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
   assign pop = !empty && gap == '0;
   assign push = accept && (!full || pop);
   assign drop = accept && full && !pop;
   always_comb begin
      state_d = state;
      nonce_d = bus.hash_nonce;
      if (bus.new_work) begin
         state_d = bus.nonce_min <= bus.nonce_max ? RUN : DONE;
         nonce_d = bus.nonce_min;
      end else if (xfer) begin
         state_d = last ? DONE : RUN;
         nonce_d = last ? bus.hash_nonce : bus.hash_nonce + 32'd1;
      end
   end
   always_ff @(posedge hash_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge hash_clk or negedge rst_n)
      if (!rst_n) begin
         bus.hash_midstate <= '0;
         bus.hash_data <= '0;
         bus.hash_nonce <= '0;
         bus.hash_job <= '0;
         nonce_max_q <= '0;
         bus.overflow <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         gap <= '0;
         bus.golden_nonce <= '0;
         bus.new_golden_ticket <= 1'b0;
      end else begin
         if (bus.new_work) begin
            bus.hash_midstate <= bus.midstate;
            bus.hash_data <= bus.work_data;
            bus.hash_job <= bus.hash_job + 2'd1;
            nonce_max_q <= bus.nonce_max;
         end
         bus.hash_nonce <= nonce_d;
         bus.overflow <= bus.new_work ? 1'b0 : bus.overflow | drop;
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         gap <= pop ? GW'(TICKET_GAP - 1) : gap != '0 ? gap - 1'b1 : gap;
         bus.golden_nonce <= pop ? mem[rd_ptr[AW-1:0]] : bus.golden_nonce;
         bus.new_golden_ticket <= pop;
      end
   always_ff @(posedge hash_clk)
      if (push) mem[wr_ptr[AW-1:0]] <= bus.hit_nonce;
endmodule

// File: tb/tb_nonce_sequencer.sv
// tb_nonce_sequencer: directed and random stimulus against a queue-based reference of sweep and ticket behaviour.
module tb_nonce_sequencer;
   localparam int DEPTH = 4;
   localparam int GAP = 64;
   logic hash_clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 hash_clk = ~hash_clk;
   nonce_sequencer_if bus ();
   nonce_sequencer #(.FIFO_DEPTH(DEPTH), .TICKET_GAP(GAP)) dut (.hash_clk(hash_clk), .rst_n(rst_n), .bus(bus));
   int n_cmp = 0, n_bad = 0, n_issued = 0, n_tick = 0;
   logic [31:0] m_q [$];
   int m_gap;
   logic [31:0] m_gold, m_next;
   logic m_tick, m_ovf;
   logic [1:0] m_job;
   longint m_left;
   logic [255:0] m_mid;
   logic [95:0] m_dat;
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_q.delete();
      m_gap = 0;
      m_gold = '0;
      m_next = '0;
      m_tick = 1'b0;
      m_ovf = 1'b0;
      m_job = '0;
      m_left = 0;
      m_mid = '0;
      m_dat = '0;
   endtask
   task automatic start(input logic [31:0] lo, input logic [31:0] hi);
      bus.new_work = 1'b1;
      bus.midstate = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.work_data = {$urandom, $urandom, $urandom};
      bus.nonce_min = lo;
      bus.nonce_max = hi;
   endtask
   task automatic give_hit(input logic [31:0] n, input logic [1:0] j);
      bus.hit = 1'b1;
      bus.hit_nonce = n;
      bus.hit_job = j;
   endtask
   task automatic cycle();
      logic xfer, acc;
      xfer = bus.hash_valid && bus.hash_ready;
      acc = bus.hit;
`ifdef NONCE_SEQ_STALE_FILTER_EN
      acc = acc && bus.hit_job == m_job;
`endif
      if (xfer) begin
         n_issued++;
         check("issue_nonce", bus.hash_nonce, m_next);
      end
      @(posedge hash_clk);
      if (m_q.size() > 0 && m_gap == 0) begin
         m_gold = m_q.pop_front();
         m_tick = 1'b1;
         m_gap = GAP - 1;
      end else begin
         m_tick = 1'b0;
         if (m_gap > 0) m_gap--;
      end
      if (acc) begin
         if (m_q.size() < DEPTH) m_q.push_back(bus.hit_nonce);
         else m_ovf = 1'b1;
      end
      if (xfer && m_left > 0) begin
         m_left--;
         m_next++;
      end
      if (bus.new_work) begin
         m_mid = bus.midstate;
         m_dat = bus.work_data;
         m_job++;
         m_ovf = 1'b0;
         m_next = bus.nonce_min;
         m_left = bus.nonce_min <= bus.nonce_max ? longint'(bus.nonce_max) - longint'(bus.nonce_min) + 1 : 0;
      end
      @(negedge hash_clk);
      if (bus.new_golden_ticket) n_tick++;
      check("ticket", bus.new_golden_ticket, m_tick);
      check("golden", bus.golden_nonce, m_gold);
      check("overflow", bus.overflow, m_ovf);
      check("busy", bus.busy, m_left > 0);
      check("valid", bus.hash_valid, m_left > 0);
      check("job", bus.hash_job, m_job);
      check("midstate", bus.hash_midstate, m_mid);
      check("data", bus.hash_data, m_dat);
      if (m_left > 0) check("nonce", bus.hash_nonce, m_next);
      bus.new_work = 1'b0;
      bus.hit = 1'b0;
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask
   task automatic sweep_done(input int budget);
      for (int i = 0; i < budget && bus.busy; i++) cycle();
      check("sweep_end_busy", bus.busy, 1'b0);
   endtask
   initial begin
      bus.new_work = 1'b0;
      bus.midstate = '0;
      bus.work_data = '0;
      bus.nonce_min = '0;
      bus.nonce_max = '0;
      bus.hash_ready = 1'b1;
      bus.hit = 1'b0;
      bus.hit_nonce = '0;
      bus.hit_job = '0;
      model_reset();
      #1;
      check("rst_valid", bus.hash_valid, 1'b0);
      check("rst_nonce", bus.hash_nonce, 32'd0);
      check("rst_job", bus.hash_job, 2'd0);
      check("rst_golden", bus.golden_nonce, 32'd0);
      check("rst_ticket", bus.new_golden_ticket, 1'b0);
      check("rst_overflow", bus.overflow, 1'b0);
      @(negedge hash_clk);
      rst_n = 1'b1;
      run(2);
      n_issued = 0;
      start(32'h10, 32'h13);
      cycle();
      sweep_done(20);
      check("sweep_count", n_issued, 4);
      check("sweep_job", bus.hash_job, 2'd1);
      n_issued = 0;
      start(32'hFFFFFFFE, 32'hFFFFFFFF);
      cycle();
      sweep_done(20);
      run(3);
      check("top_count", n_issued, 2);
      n_issued = 0;
      start(32'd5, 32'd4);
      cycle();
      check("empty_busy", bus.busy, 1'b0);
      run(3);
      check("empty_count", n_issued, 0);
      n_issued = 0;
      start(32'd0, 32'd5);
      cycle();
      for (int i = 0; i < 40 && bus.busy; i++) begin
         bus.hash_ready = (i % 4 == 0) || (i % 4 == 3);
         cycle();
      end
      bus.hash_ready = 1'b1;
      check("bp_count", n_issued, 6);
      n_tick = 0;
      give_hit(32'hAAAA0001, m_job);
      cycle();
      give_hit(32'hAAAA0002, m_job);
      cycle();
      give_hit(32'hAAAA0003, m_job);
      cycle();
      run(3 * GAP);
      check("pace_tickets", n_tick, 3);
      check("pace_last", bus.golden_nonce, 32'hAAAA0003);
      n_tick = 0;
      for (int i = 0; i < 6; i++) begin
         give_hit(32'hBB000000 + i, m_job);
         cycle();
      end
      check("ovf_set", bus.overflow, 1'b1);
      run(5 * GAP + 4);
      check("ovf_tickets", n_tick, 5);
      start(32'd1, 32'd1);
      cycle();
      check("ovf_clear", bus.overflow, 1'b0);
      run(4);
      while (m_job != 2'd2) begin
         start(32'd7, 32'd3);
         cycle();
      end
      n_tick = 0;
      give_hit(32'hC0000001, 2'd1);
      cycle();
      run(GAP + 2);
      give_hit(32'hC0000002, 2'd2);
      cycle();
      run(GAP + 2);
`ifdef NONCE_SEQ_STALE_FILTER_EN
      check("stale_tickets", n_tick, 1);
`else
      check("stale_tickets", n_tick, 2);
`endif
      start(32'd0, 32'd1000);
      cycle();
      give_hit(32'hD0000001, m_job);
      cycle();
      give_hit(32'hD0000002, m_job);
      run(4);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", bus.hash_valid, 1'b0);
      check("arst_nonce", bus.hash_nonce, 32'd0);
      check("arst_job", bus.hash_job, 2'd0);
      check("arst_golden", bus.golden_nonce, 32'd0);
      model_reset();
      @(negedge hash_clk);
      rst_n = 1'b1;
      run(GAP + 4);
      for (int i = 0; i < 3000; i++) begin
         bus.hash_ready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 59) == 0) begin
            logic [31:0] lo, hi;
            lo = $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            hi = lo + 32'($urandom_range(0, 40));
            if ($urandom_range(0, 5) == 0) hi = lo - 32'd1;
            start(lo, hi);
         end
         if ($urandom_range(0, 19) == 0) give_hit($urandom, 2'($urandom_range(0, 3)));
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
